bcd_serial_adder_ctrl: RTL and testbench

- Digit-serial N-digit BCD adder controller.
- Captures two packed-BCD operands on a start handshake.
- Sequences one shared single-digit BCD adder stage (LS digit first), one digit per clock, propagating the decimal carry through a carry register.
- Presents the result with a one-cycle done pulse.
- Area-saving alternative to a ripple chain of per-digit adders, for lab datapaths needing multi-digit decimal sums.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic bcd_digit_valid(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder stage: raw binary sum, decimal-adjusted when above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] s;

    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > {1'b0, BCD_MAX}) begin
            digit = s[3:0] + BCD_ADJ;
            cout  = 1'b1;
        end else begin
            digit = s[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial N-digit BCD adder controller, LS digit first, one digit per clock.
// Defining BCD_SERIAL_SUB_EN adds a sub input selecting nines-complement subtraction.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef BCD_SERIAL_SUB_EN
    input  logic                sub,
`endif
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] op_a;
    logic [4*DIGITS-1:0] op_b;
    logic [4*DIGITS-1:0] sum_q;
    logic                carry;
    logic                cout_q;
    logic                invalid_q;
    logic                accept;
    logic                invalid_in;
    logic                carry_init;
    logic [3:0]          b_digit;
    logic [3:0]          digit;
    logic                carry_next;

    assign accept = start && (state == IDLE || state == DONE);

    always_comb begin
        invalid_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(a[4*i +: 4]) || !bcd_digit_valid(b[4*i +: 4]))
                invalid_in = 1'b1;
        end
    end

`ifdef BCD_SERIAL_SUB_EN
    logic sub_q;
    // Subtraction is A + nines-complement(B) + 1; the wrap on raw invalid digits is harmless.
    assign b_digit    = sub_q ? (BCD_MAX - op_b[3:0]) : op_b[3:0];
    assign carry_init = sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sub_q <= 1'b0;
        else if (accept)
            sub_q <= sub;
    end
`else
    assign b_digit    = op_b[3:0];
    assign carry_init = 1'b0;
`endif

    bcd_digit_add u_digit_add (
        .a     (op_a[3:0]),
        .b     (b_digit),
        .cin   (carry),
        .digit (digit),
        .cout  (carry_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            sum_q     <= '0;
            carry     <= 1'b0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else if (accept) begin
            state     <= RUN;
            cnt       <= '0;
            op_a      <= a;
            op_b      <= b;
            carry     <= carry_init;
            cout_q    <= 1'b0;
            invalid_q <= invalid_in;
        end else begin
            case (state)
                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt == CNT_W'(i))
                            sum_q[4*i +: 4] <= digit;
                    end
                    // Operands shift right so the active digit always sits in [3:0].
                    op_a  <= op_a >> 4;
                    op_b  <= op_b >> 4;
                    carry <= carry_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cout_q <= carry_next;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed self-checking bench for bcd_serial_adder_ctrl (DIGITS=3).
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
`ifdef BCD_SERIAL_SUB_EN
    logic         sub   = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef BCD_SERIAL_SUB_EN
        .sub     (sub),
`endif
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE; operands are scrambled during RUN to prove they are not resampled.
    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vsub, input logic [W-1:0] esum,
                          input logic ecout, input logic einv);
        int busy_cycles;
        start = 1'b1;
        a     = va;
        b     = vb;
`ifdef BCD_SERIAL_SUB_EN
        sub   = vsub;
`else
        if (vsub) $display("note: %s requests subtraction in an add-only build", tag);
`endif
        tick();
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            busy_cycles++;
            tick();
        end
        check({tag, "_busy_cycles"}, busy_cycles, DIGITS);
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_invalid"}, invalid, einv);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_sum_hold"}, sum, esum);
    endtask

    initial begin
        int seen;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_invalid", invalid, 0);
        rst_n = 1'b1;
        tick();

        run_op("add_123_456", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);
        run_op("add_999_001", 12'h999, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);

        // Back-to-back: start held through DONE, operands switched mid-RUN.
        start = 1'b1;
        a = 12'h123;
        b = 12'h456;
        tick();
        a = 12'h500;
        b = 12'h500;
        tick();
        tick();
        tick();
        check("b2b_first_done", done, 1);
        check("b2b_first_sum", sum, 12'h579);
        check("b2b_first_cout", cout, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) seen++;
        end
        start = 1'b0;
        check("b2b_done_in_gap", seen, 1);
        check("b2b_second_done", done, 1);
        check("b2b_second_sum", sum, 12'h000);
        check("b2b_second_cout", cout, 1);
        tick();
        check("b2b_back_to_idle", done, 0);

        run_op("inv_00a_001", 12'h00A, 12'h001, 1'b0, 12'h011, 1'b0, 1'b1);
        run_op("add_111_222", 12'h111, 12'h222, 1'b0, 12'h333, 1'b0, 1'b0);

        // Reset asserted during the second RUN cycle.
        start = 1'b1;
        a = 12'h777;
        b = 12'h111;
        tick();
        start = 1'b0;
        tick();
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_invalid", invalid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen++;
        end
        check("midrst_no_activity", seen, 0);
        run_op("post_rst_123_456", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);

`ifdef BCD_SERIAL_SUB_EN
        run_op("sub_500_123", 12'h500, 12'h123, 1'b1, 12'h377, 1'b1, 1'b0);
        run_op("sub_123_500", 12'h123, 12'h500, 1'b1, 12'h623, 1'b0, 1'b0);
        run_op("sub0_add_123_456", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
